// File: rtl/store_buffer.sv
// Posted-write store buffer between the M-stage memory port and a slower handshaked data memory.
// Stores queue in a DEPTH-entry FIFO; loads forward from the newest matching entry or stall for a memory read.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemWriteM,
  input  logic                   MemReadM,
  input  logic [AW-1:0]          ALUOutM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic                   StallM,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic [1:0]             dbg_state_o,
  output logic [$clog2(DEPTH):0] dbg_count_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WDRAIN = 2'd1,
    S_RREQ   = 2'd2,
    S_RDONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;
  logic [AW-3:0] addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic          full;
  logic          push;
  logic          pop;
  logic          hit;
  logic          load_miss;
  logic [31:0]   fwd_data;
  logic [PW-1:0] scan_idx;
  logic [PW:0]   count_d;
  logic [AW-3:0] issue_addr;
  logic [31:0]   issue_data;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^ALUOutM[1:0];

  // Scan oldest to newest so the last match, the newest store, wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (addr_q[scan_idx] == ALUOutM[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[scan_idx];
      end
    end
  end

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign load_miss = MemReadM && !hit;
  assign push      = MemWriteM && !MemReadM && !full;
  // Memory handshake: mem_req with its attributes is held until a one-cycle
  // mem_ack completes it; an ack seen while mem_req is low is ignored.
  assign pop       = (state_q == S_WDRAIN) && mem_req_q && mem_ack;
  assign count_d   = count_q + (PW+1)'(push) - (PW+1)'(pop);

  // An empty buffer issues the store being pushed this cycle directly.
  assign issue_addr = (count_q == '0) ? ALUOutM[AW-1:2] : addr_q[head_q];
  assign issue_data = (count_q == '0) ? WriteDataM      : data_q[head_q];

  always_comb begin
    StallM = 1'b0;
    if (MemReadM) begin
      StallM = !hit && (state_q != S_RDONE);
    end else if (MemWriteM) begin
      StallM = full;
    end
  end

  assign ReadDataM = hit ? fwd_data : rdata_q;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= ALUOutM[AW-1:2];
      data_q[tail_q] <= WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if ((count_q != '0) || push) begin
            state_q     <= S_WDRAIN;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {issue_addr, 2'b00};
            mem_wdata_q <= issue_data;
          end else if (load_miss) begin
            state_q    <= S_RREQ;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {ALUOutM[AW-1:2], 2'b00};
          end
        end
        S_WDRAIN: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {addr_q[head_q], 2'b00};
            mem_wdata_q <= data_q[head_q];
          end else if (mem_ack) begin
            // Request always drops for a cycle after an ack.
            mem_req_q <= 1'b0;
            if (count_d != '0) begin
              state_q <= S_WDRAIN;
            end else if (load_miss) begin
              state_q <= S_RREQ;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_RREQ: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {ALUOutM[AW-1:2], 2'b00};
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            rdata_q   <= mem_rdata;
            state_q   <= S_RDONE;
          end
        end
        S_RDONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write data-memory port between the `mips` core's M-stage memory interface and a slower handshaked data memory. Stores are accepted in one cycle into a DEPTH-entry FIFO and drained to memory in order. Loads that hit a buffered store are forwarded without stalling. Loads that miss stall the core, drain the buffer, and then read memory.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2
- `AW`, 32: address width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `MemWriteM`  in  1  store request
- `MemReadM`  in  1  load request
- `ALUOutM`  in  AW  byte address; bits [1:0] ignored (word access only)
- `WriteDataM`  in  32  store data
- `ReadDataM`  out  32  load data, valid when `MemReadM`=1 and `StallM`=0
- `StallM`  out  1  core must hold all M-stage inputs stable while high
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  AW  word-aligned address ([1:0]=0)
- `mem_wdata`  out  32  write data
- `mem_ack`  in  1  one-cycle completion pulse
- `mem_rdata`  in  32  read data, valid with `mem_ack` on reads

## Operation
- The FIFO holds {addr[AW-1:2], data} per entry. It has head/tail pointers that wrap modulo DEPTH and a count of 0..DEPTH.
- Store with count<DEPTH: push in the same cycle, `StallM`=0.
- Store with count==DEPTH: `StallM`=1 and no push.
  - `StallM` is derived from the registered count only. A full buffer stalls for at least one cycle even if `mem_ack` pops in that cycle.
  - The push happens on the first cycle with count<DEPTH.
- A push and a pop in the same cycle are both performed; count is unchanged.
- Load hit: any valid entry's address matches `ALUOutM[AW-1:2]`.
  - `ReadDataM` is the data of the newest matching entry, combinationally.
  - `StallM`=0. No memory access.
- Load miss: `StallM`=1 until the load completes (see FSM).
- `MemReadM` and `MemWriteM` both high: treated as a load only; no push.
- FSM states:
  - IDLE
    - count>0 → WDRAIN, issue head entry.
    - load miss with count==0 → RREQ.
    - load miss with count>0 → WDRAIN; the load waits.
  - WDRAIN
    - `mem_req`=1, `mem_we`=1, addr/data = head entry, all held until `mem_ack`.
    - On ack: pop.
    - Next state: WDRAIN again (new head, req reasserted next cycle) if count after pop >0; else RREQ if a load miss is pending; else IDLE.
  - RREQ
    - `mem_req`=1, `mem_we`=0, `mem_addr`={`ALUOutM`[AW-1:2],2'b00}.
    - On ack: latch `mem_rdata` into the read register → RDONE.
  - RDONE
    - `ReadDataM` = latched word, `StallM`=0 for exactly one cycle → IDLE.
- Store during WDRAIN or RREQ: accepted if not full. Order is preserved; the push never alters the entry being issued.
- `mem_req` drops for at least one cycle after every ack; there are no back-to-back requests.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset mid-operation: the outstanding request is abandoned and buffered stores are discarded. After reset the first `mem_ack` pulse is ignored unless `mem_req`=1.

## Timing
- Reset values:
  - count=0, pointers=0, FSM=IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Read register 0, so `ReadDataM`=0; `StallM`=0.
- Store: zero stall cycles when not full. The entry is forwardable from the next cycle.
- The earliest `mem_req` for a pushed store is the cycle after the push, when the buffer was previously empty and the FSM was IDLE.
- Load miss, empty buffer, memory ack latency L (ack L cycles after req rises, L≥1):
  - cycle 0: load presented, `StallM`=1
  - cycle 1: `mem_req`=1
  - cycle 1+L: ack
  - cycle 2+L: RDONE, `StallM`=0, data valid
  - Total stall = 2+L cycles.
- Load hit: zero cycles.
- Write drain throughput: one store per L+2 cycles (req, L, one idle cycle).

## Test plan
- **Reset state:** reset, then 3 idle cycles → all outputs 0, `StallM`=0, no `mem_req`.
- **Store then forward:** store 0x100←0xDEADBEEF, then load 0x100 next cycle → `ReadDataM`=0xDEADBEEF with `StallM`=0.
  - Memory later receives the write (0x100, 0xDEADBEEF).
- **Newest-match forwarding:** stores 0x40←1, 0x40←2, then load 0x40 → 2.
  - Memory sees the writes in order 1 then 2.
- **Full buffer:** 5 back-to-back stores with DEPTH=4 and L=3 → `StallM`=1 on the 5th store until the first ack has popped.
  - All 5 writes reach memory in order; pointers wrap correctly.
- **Load miss with pending stores:** 2 queued stores, then load 0x200 (memory holds 0x12345678), L=2 → both writes complete before the read request.
  - `ReadDataM`=0x12345678 with `StallM`=0 for one cycle.
- **Reset mid-read:** assert `rst` during RREQ → `mem_req`=0 next cycle, FSM IDLE, count=0.
  - A late `mem_ack` is ignored.
